// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiply-accumulate frame summer.
// Holds the FSM state encoding and the default frame/accumulator sizes.
// No logic lives here; imported by mul_accum and acc_add.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int FRAME_LEN_DEF = 8;
    localparam int ACC_W_DEF     = 12;
    localparam int PROD_W        = 8;
    // Wide enough to hold a count of 16 products.
    localparam int CNT_W         = 5;

endpackage

// File: rtl/mul_accum_acc_add.sv
// Extends an 8-bit product to ACC_W bits and adds it to the accumulator.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the result is committed.
module acc_add
    import mul_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int SIGNED_IN = 1
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   full;

    // Extend the product, add with a carry bit, and flag overflow per signedness.
    always_comb begin
        if (SIGNED_IN != 0) begin
            ext = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
        end else begin
            ext = {{(ACC_W-PROD_W){1'b0}}, prod_i};
        end
        full  = {1'b0, acc_i} + {1'b0, ext};
        sum_o = full[ACC_W-1:0];
        if (SIGNED_IN != 0) begin
            // Signed overflow: operands agree in sign but the result does not.
            ovf_o = (acc_i[ACC_W-1] == ext[ACC_W-1]) && (sum_o[ACC_W-1] != acc_i[ACC_W-1]);
        end else begin
            ovf_o = full[ACC_W];
        end
    end

endmodule

// File: rtl/mul_accum.sv
// Sums FRAME_LEN multiplier products per frame and presents the sum with an overflow flag.
// Latency 1 cycle: out_valid rises on the edge that accepts the last product of a frame.
// in_ready drops while a sum is pending; a sum is held stable until out_ready takes it.
module mul_accum
    import mul_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int SIGNED_IN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             in_xfer;

    // The accumulator is zero in IDLE, so adding to it doubles as the first-product load.
    acc_add #(
        .ACC_W     (ACC_W),
        .SIGNED_IN (SIGNED_IN)
    ) u_acc_add (
        .acc_i  (acc_q),
        .prod_i (in_prod),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    // Handshake decode and next count; outputs come straight from registered state.
    always_comb begin
        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
        out_sum   = acc_q;
        out_ovf   = ovf_q;
        in_xfer   = in_valid && in_ready;
        cnt_d     = cnt_q + 1'b1;
    end

    // Frame FSM: clr beats any transfer; DONE holds until the sum is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        acc_q   <= add_sum;
                        cnt_q   <= CNT_W'(1);
                        ovf_q   <= add_ovf;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (in_xfer) begin
                        acc_q <= add_sum;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_q | add_ovf;
                        if (cnt_d == LAST_CNT) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, setting the number of products summed per frame (legal range 2..16).
REQ-002 The block SHALL have parameter ACC_W, default 12, setting the width of the accumulator and of out_sum.
REQ-003 The block SHALL have parameter SIGNED_IN, default 1: 1 means in_prod is two's complement, 0 means unsigned.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous frame abort.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the 8-bit multiplier product is present.
REQ-008 The block SHALL have port in_prod, input, 8 bits: the product from the 4x4 multiplier stage.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts in_prod this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a frame sum is available.
REQ-011 The block SHALL have port out_sum, output, ACC_W bits: the frame sum.
REQ-012 The block SHALL have port out_ovf, output, 1 bit: the frame sum overflowed ACC_W.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream consumes the sum.

Function
REQ-014 The block SHALL implement states IDLE, ACC and DONE.
REQ-015 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL equal 1 in IDLE and ACC, and 0 in DONE.
REQ-017 An input transfer in IDLE SHALL load the accumulator with ext(in_prod), set the count to 1, and move to ACC.
REQ-018 ext() SHALL be sign-extension when SIGNED_IN=1 and zero-extension when SIGNED_IN=0.
REQ-019 An input transfer in ACC SHALL add ext(in_prod) to the accumulator and increment the count.
REQ-020 The transfer that brings the count to FRAME_LEN SHALL move the block to DONE on that same edge.
REQ-021 out_valid SHALL be 1 exactly while in DONE.
REQ-022 While out_valid=1, out_sum and out_ovf SHALL remain stable until the output transfer.
REQ-023 An output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1; it SHALL return the block to IDLE and clear the accumulator, count and ovf.
REQ-024 Latency SHALL be 1 cycle: out_valid rises on the edge that accepts the FRAME_LEN-th product.
REQ-025 No input SHALL be accepted in the cycle of an output transfer; the next frame starts no earlier than the following edge.
REQ-026 Overflow detection SHALL follow the signedness rule:
- SIGNED_IN=1: ovf sets if any addition produces a signed overflow of ACC_W bits.
- SIGNED_IN=0: ovf sets if any addition produces a carry out of ACC_W bits.
REQ-027 Once set, ovf SHALL stay sticky until the frame ends.
REQ-028 On overflow the accumulator SHALL wrap modulo 2^ACC_W; it SHALL NOT saturate.
REQ-029 clr=1 SHALL force IDLE and clear the accumulator, count and ovf on the next edge, in any state.
REQ-030 clr SHALL take priority over simultaneous input and output transfers; a product presented with clr=1 is discarded.
REQ-031 in_valid=0 in ACC SHALL hold all state, with no timeout.
REQ-032 out_ready=0 in DONE SHALL hold all state indefinitely.

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, accumulator 0, count 0, ovf 0.
REQ-034 During reset the outputs SHALL be in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-035 Reset asserted mid-frame or in DONE SHALL discard the partial or pending sum; no output transfer occurs.
REQ-036 Release of rst SHALL take effect at the next rising edge of clk.

Structure
REQ-037 The state encoding (IDLE=2'b00, ACC=2'b01, DONE=2'b10) SHALL be defined in shared package mul_pkg; the default FRAME_LEN and ACC_W SHALL also be defined there.
REQ-038 The extend-and-add with overflow detection SHALL be one combinational sub-module, acc_add.
REQ-039 Control and registers SHALL remain in mul_accum.

Verification
REQ-040 Basic frame: SIGNED_IN=1, products 10,20,30,40,50,60,70,80 back-to-back with out_ready=1 -> out_valid for 1 cycle, out_sum=360, out_ovf=0, then in_ready=1.
REQ-041 Signed negatives: products 8'hF0 (-16) x8 -> out_sum=12'hF80 (-128), out_ovf=0.
REQ-042 Backpressure: a full frame with out_ready=0 for 5 cycles, then in_valid=1 held -> in_ready=0 and out_sum stable for 5 cycles, and no product is accepted until after the output transfer.
REQ-043 Overflow: FRAME_LEN=16, SIGNED_IN=0, products 255 x16 -> out_sum=4080, out_ovf=0; with ACC_W=11 -> out_ovf=1 and out_sum=4080 mod 2048 = 2032.
REQ-044 Abort and reset: clr=1 after the 3rd product, then 8 products of value 1 -> out_sum=8; rst=0 after 5 products -> immediate out_valid=0, and after release a fresh 8-product frame sums correctly.
REQ-045 Idle gaps: a random in_valid pattern with gaps across a frame -> sum equals the reference model, and the count never advances on in_valid=0.
